// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and default parameters for the alarm ringer
//
// Purpose: ringer state encoding and default timing/snooze parameters used by
//          alarm_ringer and ringer_beep_gen.
// Ports:   none (package).
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } ring_state_e;

  localparam int BEEP_PERIOD_DEF    = 8;
  localparam int RING_TIMEOUT_S_DEF = 60;
  localparam int SNOOZE_S_DEF       = 300;
  localparam int MAX_SNOOZE_DEF     = 3;

endpackage

// File: rtl/ringer_beep_gen.sv
// rtl/ringer_beep_gen.sv - beep pattern counter for the alarm ringer
//
// Purpose: free-running 0..BEEP_PERIOD-1 counter with synchronous clear and
//          count enable; pattern is high for the first half of each period.
// Ports:
//   clk     in  clock
//   clear   in  synchronous clear to 0 (wins over enable)
//   enable  in  advance the counter this cycle
//   pattern out high while the count is in the first half of the period
module ringer_beep_gen
  import alarm_pkg::*;
#(
  parameter int BEEP_PERIOD = BEEP_PERIOD_DEF
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic pattern
);

  localparam int CW = $clog2(BEEP_PERIOD);

  logic [CW-1:0] beep_cnt;

  always_ff @(posedge clk) begin
    if (clear) begin
      beep_cnt <= '0;
    end else if (enable) begin
      beep_cnt <= (beep_cnt == CW'(BEEP_PERIOD - 1)) ? '0 : beep_cnt + CW'(1);
    end
  end

  assign pattern = (beep_cnt < CW'(BEEP_PERIOD / 2));

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - buzzer sequencer with snooze, stop and ring timeout
//
// Purpose: turns the rising edge of alarm_triggered into a beeping ring,
//          handles snooze/stop button pulses and silences after a timeout.
//          Optional macro ALARM_RINGER_ESCALATE_EN: once all snoozes are used,
//          the buzzer is driven steadily while ringing instead of pulsed.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   alarm_triggered  alarm level from the clock core (rising edge starts a ring)
//   sec_tick         one-cycle pulse per second
//   snooze, stop     one-cycle debounced button pulses
//   buzzer           beep drive
//   ringing          high while ringing
//   snoozing         high while snoozed
//   snooze_count     snoozes used in the current alarm event
//   missed           one-cycle pulse when ringing times out unanswered
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int BEEP_PERIOD    = BEEP_PERIOD_DEF,
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int SNOOZE_S       = SNOOZE_S_DEF,
  parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alarm_triggered,
  input  logic                              sec_tick,
  input  logic                              snooze,
  input  logic                              stop,
  output logic                              buzzer,
  output logic                              ringing,
  output logic                              snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_count,
  output logic                              missed
);

  localparam int SCW = $clog2(MAX_SNOOZE + 1);
  localparam int RW  = $clog2(RING_TIMEOUT_S + 1);
  localparam int SW  = $clog2(SNOOZE_S + 1);

  localparam logic [SCW-1:0] SC_MAX   = SCW'(MAX_SNOOZE);
  localparam logic [RW-1:0]  RING_END = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0]  SNZ_END  = SW'(SNOOZE_S - 1);

  ring_state_e   state;
  logic          trig_q;
  logic [RW-1:0] ring_sec;
  logic [SW-1:0] snz_sec;
  logic          edge_seen;
  logic          snz_expire;
  logic          enter_ring;
  logic          pattern;

  assign edge_seen  = alarm_triggered & ~trig_q;
  assign snz_expire = (state == SNOOZE) & ~stop & sec_tick & (snz_sec == SNZ_END);
  // Every entry into RING restarts the beep so the first ringing cycle is high.
  assign enter_ring = ((state == IDLE) & edge_seen) | snz_expire;

  ringer_beep_gen #(
    .BEEP_PERIOD(BEEP_PERIOD)
  ) u_beep (
    .clk    (clk),
    .clear  (rst | enter_ring),
    .enable (state == RING),
    .pattern(pattern)
  );

  always_ff @(posedge clk) begin
    // trig_q keeps sampling during reset so a level still high when reset
    // releases is not mistaken for a fresh edge.
    trig_q <= alarm_triggered;
    if (rst) begin
      state        <= IDLE;
      ring_sec     <= '0;
      snz_sec      <= '0;
      snooze_count <= '0;
      missed       <= 1'b0;
    end else begin
      missed <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_seen) begin
            state        <= RING;
            snooze_count <= '0;
            ring_sec     <= '0;
          end
        end
        RING: begin
          if (stop) begin
            state        <= IDLE;
            snooze_count <= '0;
          end else if (snooze && (snooze_count < SC_MAX)) begin
            state        <= SNOOZE;
            snooze_count <= snooze_count + SCW'(1);
            snz_sec      <= '0;
          end else if (sec_tick) begin
            // A snooze refused at the limit has no effect, so the tick
            // still counts toward the timeout.
            if (ring_sec == RING_END) begin
              state  <= IDLE;
              missed <= 1'b1;
            end else begin
              ring_sec <= ring_sec + RW'(1);
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state        <= IDLE;
            snooze_count <= '0;
          end else if (sec_tick) begin
            if (snz_sec == SNZ_END) begin
              state    <= RING;
              ring_sec <= '0;
            end else begin
              snz_sec <= snz_sec + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ringing  = (state == RING);
  assign snoozing = (state == SNOOZE);

`ifdef ALARM_RINGER_ESCALATE_EN
  assign buzzer = ringing & (pattern | (snooze_count == SC_MAX));
`else
  assign buzzer = ringing & pattern;
`endif

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed scoreboard bench for alarm_ringer
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       rst;
  logic       alarm_triggered;
  logic       sec_tick;
  logic       snooze;
  logic       stop;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_count;
  logic       missed;

  always #5 clk = ~clk;

  alarm_ringer #(
    .BEEP_PERIOD   (8),
    .RING_TIMEOUT_S(3),
    .SNOOZE_S      (2),
    .MAX_SNOOZE    (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alarm_triggered(alarm_triggered),
    .sec_tick       (sec_tick),
    .snooze         (snooze),
    .stop           (stop),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozing       (snoozing),
    .snooze_count   (snooze_count),
    .missed         (missed)
  );

`ifdef ALARM_RINGER_ESCALATE_EN
  localparam bit ESC = 1'b1;
`else
  localparam bit ESC = 1'b0;
`endif

  typedef struct {
    logic [5:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected output bundle: {buzzer, ringing, snoozing, missed, snooze_count}
  function automatic logic [5:0] pk(logic b, logic r, logic s, logic m, logic [1:0] c);
    return {b, r, s, m, c};
  endfunction

  // Beep is high for cycles 0..3 of each 8-cycle period after ring entry.
  function automatic logic pat(int p);
    return ((p % 8) < 4);
  endfunction

  // Drive one cycle of inputs (at the falling edge), queue what the outputs
  // must be after the next rising edge, then check at the following falling edge.
  task automatic step(input logic r, input logic trg, input logic tk, input logic sz,
                      input logic sp, input logic [5:0] exp, input string tag);
    exp_t       e;
    logic [5:0] obs;
    rst             = r;
    alarm_triggered = trg;
    sec_tick        = tk;
    snooze          = sz;
    stop            = sp;
    sb.push_back('{exp, tag});
    @(negedge clk);
    e   = sb.pop_front();
    obs = {buzzer, ringing, snoozing, missed, snooze_count};
    checks++;
    assert (obs === e.exp)
    else begin
      errors++;
      $error("FAIL %s observed={buz,ring,snz,miss,cnt}=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    rst = 1'b1; alarm_triggered = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
    @(negedge clk);

    // Reset state and idle behaviour
    step(1, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "reset");
    step(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "idle");
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 1, 1, pk(0, 0, 0, 0, 2'd0), "idle_ignores_buttons");

    // Rising edge, then hold the level high: pattern 1111 0000, no restart
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd0), "edge_ring");
    for (int k = 1; k < 100; k++)
      step(0, 1, 0, 0, 0, pk(pat(k), 1, 0, 0, 2'd0), "beep_hold");

    // Timeout after three ticks in RING
    step(0, 1, 1, 0, 0, pk(pat(100), 1, 0, 0, 2'd0), "tick1");
    step(0, 1, 0, 0, 0, pk(pat(101), 1, 0, 0, 2'd0), "between_ticks");
    step(0, 1, 1, 0, 0, pk(pat(102), 1, 0, 0, 2'd0), "tick2");
    step(0, 1, 1, 0, 0, pk(0, 0, 0, 1, 2'd0), "timeout_missed");
    step(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "missed_one_cycle");

    // Snooze cycles up to the limit
    step(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "trig_low");
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd0), "edge2");
    step(0, 1, 0, 1, 0, pk(0, 0, 1, 0, 2'd1), "snooze1");
    step(0, 1, 0, 1, 0, pk(0, 0, 1, 0, 2'd1), "snooze_in_snooze_ignored");
    step(0, 1, 1, 0, 0, pk(0, 0, 1, 0, 2'd1), "snz_tick1");
    step(0, 1, 1, 0, 0, pk(1, 1, 0, 0, 2'd1), "snz_expire");
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd1), "beep_restart");
    step(0, 1, 0, 1, 0, pk(0, 0, 1, 0, 2'd2), "snooze2");
    step(0, 1, 1, 0, 0, pk(0, 0, 1, 0, 2'd2), "snz2_tick1");
    step(0, 1, 1, 0, 0, pk(1, 1, 0, 0, 2'd2), "snz2_expire");
    step(0, 1, 0, 1, 0, pk(0, 0, 1, 0, 2'd3), "snooze3");
    step(0, 1, 1, 0, 0, pk(0, 0, 1, 0, 2'd3), "snz3_tick1");
    step(0, 1, 1, 0, 0, pk(1, 1, 0, 0, 2'd3), "snz3_expire");
    step(0, 1, 0, 1, 0, pk(ESC | pat(1), 1, 0, 0, 2'd3), "snooze4_ignored");
    for (int p = 2; p < 10; p++)
      step(0, 1, 0, 0, 0, pk(ESC | pat(p), 1, 0, 0, 2'd3), "max_snooze_buzz");
    step(0, 1, 0, 0, 1, pk(0, 0, 0, 0, 2'd0), "stop_ring");

    // stop, snooze and terminal tick together: stop wins, no missed pulse
    step(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "trig_low2");
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd0), "edge3");
    step(0, 1, 1, 0, 0, pk(1, 1, 0, 0, 2'd0), "sim_tick1");
    step(0, 1, 1, 0, 0, pk(1, 1, 0, 0, 2'd0), "sim_tick2");
    step(0, 1, 1, 1, 1, pk(0, 0, 0, 0, 2'd0), "simultaneous");
    step(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "simultaneous_no_missed");

    // Stop while snoozing
    step(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "trig_low3");
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd0), "edge4");
    step(0, 1, 0, 1, 0, pk(0, 0, 1, 0, 2'd1), "snooze_then_stop");
    step(0, 1, 0, 0, 1, pk(0, 0, 0, 0, 2'd0), "stop_snooze");

    // Reset mid-snooze with the alarm level still high
    step(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "trig_low4");
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd0), "edge5");
    step(0, 1, 0, 1, 0, pk(0, 0, 1, 0, 2'd1), "snooze_before_rst");
    step(1, 1, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "rst_mid_snooze");
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "no_rering_after_rst");
    step(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 2'd0), "trig_low5");
    step(0, 1, 0, 0, 0, pk(1, 1, 0, 0, 2'd0), "fresh_edge_after_rst");
    step(0, 1, 0, 0, 1, pk(0, 0, 0, 0, 2'd0), "final_stop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
